if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC and drives a one-outstanding req/resp instruction memory port.
//  Presents one fetched instruction plus its PC+4 to the IF/ID pipeline register.
//  Honours ID-stage stall and jump/branch redirect. Emits BUBBLE_INSTR when it holds no valid instruction.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC fetched first after reset
//  BUBBLE_INSTR  32'h0000_0000  instruction driven when if_valid=0 (NOP)
// PORTS
//  clk                    in   1   rising-edge clock
//  rst_n                  in   1   synchronous reset, active-low
//  cpu_en                 in   1   global advance enable; 0 freezes PC/consume/redirect
//  id_shouldStall         in   1   ID stage not accepting; held instruction must persist
//  id_shouldJumpOrBranch  in   1   redirect request from ID
//  id_target              in   32  redirect PC; bits [1:0] ignored (forced 00)
//  imem_req               out  1   request valid (combinational from state and inputs)
//  imem_addr              out  32  request address = pc
//  imem_ready             in   1   request accepted when imem_req&imem_ready
//  imem_rvalid            in   1   response valid, >=1 cycle after acceptance
//  imem_rdata             in   32  response instruction word
//  if_valid               out  1   if_instruction/if_pc_4 hold a real fetched instruction
//  if_instruction         out  32  fetched instruction, or BUBBLE_INSTR when if_valid=0
//  if_pc_4                out  32  address of the fetched instruction + 4
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=S_REQ; pc=RESET_PC; if_valid=0; if_instruction=BUBBLE_INSTR; if_pc_4=0.
//  Events, evaluated per cycle:
//   fire = cpu_en & id_shouldJumpOrBranch
//   consume = cpu_en & ~id_shouldStall & ~fire & if_valid
//  States:
//   S_REQ: imem_req = cpu_en & ~fire. On accept -> S_WAIT.
//   S_WAIT: one request outstanding. On imem_rvalid: buffer rdata, if_pc_4 = pc+4, pc <= pc+4, if_valid=1 -> S_HOLD.
//   S_HOLD: outputs stable while not consumed. On consume: if_valid=0 and outputs -> bubble.
//     In the same cycle imem_req=1; accepted -> S_WAIT, else -> S_REQ.
//   S_DISCARD: request outstanding but stale. Next imem_rvalid is dropped -> S_REQ.
//  Redirect (fire) priority: fire > consume > stall, in every state.
//   pc <= {id_target[31:2],2'b00}; if_valid <= 0; no request issued in the fire cycle.
//   From S_WAIT: no rvalid this cycle -> S_DISCARD; rvalid this cycle -> data dropped, -> S_REQ.
//   From S_HOLD/S_REQ -> S_REQ. From S_DISCARD: pc updated, stay in S_DISCARD.
//  cpu_en=0:
//   - no new request; no pc update from consume/redirect.
//   - an imem_rvalid for an outstanding request is still captured (S_WAIT->S_HOLD, S_DISCARD->S_REQ).
//  imem_rvalid in S_REQ/S_HOLD (no outstanding request) is ignored. This covers stray responses after reset mid-operation.
//  imem_addr = pc in every state; meaningful only while imem_req=1.
//  pc arithmetic is modulo 2^32: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//  Latency: with imem_ready=1 and rvalid 1 cycle after accept, the instruction is visible 2 cycles after request.
//   Steady throughput is 1 instruction per 2 cycles.
//  Never more than one outstanding request. if_instruction==BUBBLE_INSTR whenever if_valid=0.
// TESTING
//  1 Reset, RESET_PC=0x100, ready=1, rvalid 1 cycle later, rdata=0xAAAA -> imem_addr=0x100; if_valid=1, if_instruction=0xAAAA, if_pc_4=0x104.
//  2 Hold with stall=1 for 5 cycles -> outputs frozen, imem_req=0. Release stall -> next request at addr 0x104 in the same cycle.
//  3 Redirect to 0x203 while S_WAIT, rvalid arrives 2 cycles later with 0xBBBB -> 0xBBBB never on if_instruction.
//    Next request addr=0x200.
//  4 Redirect and stall both high in S_HOLD -> if_valid=0 next cycle, pc=target; redirect wins.
//  5 cpu_en=0 while S_WAIT, rvalid arrives -> captured, if_valid=1. No further request until cpu_en=1.
//  6 pc=0xFFFFFFFC fetch -> if_pc_4=0x0, next imem_addr=0x0. rst_n low mid-S_WAIT, stray rvalid -> ignored, if_valid stays 0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a one-outstanding req/resp
// instruction memory port and presents one fetched instruction plus PC+4 to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_en,
  input  logic        id_shouldStall,
  input  logic        id_shouldJumpOrBranch,
  input  logic [31:0] id_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc_4
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_WAIT    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   pc_plus4;
  logic              fire;
  logic              consume;
  logic              accept;

  // Redirect outranks consume, which outranks stall; cpu_en gates both.
  assign fire     = cpu_en & id_shouldJumpOrBranch;
  assign consume  = cpu_en & ~id_shouldStall & ~fire & if_valid;
  assign target   = id_target & 32'hFFFF_FFFC;
  assign pc_plus4 = pc + XLEN'(4);
  assign accept   = imem_req & imem_ready;
  assign imem_addr = pc;

  // Request is issued from S_REQ, or from S_HOLD in the cycle the held instruction is consumed.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      S_REQ:   imem_req = cpu_en & ~fire;
      S_HOLD:  imem_req = consume;
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch FSM with PC and registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      if_valid       <= 1'b0;
      if_instruction <= BUBBLE_INSTR;
      if_pc_4        <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (fire) begin
            pc <= target;
          end else if (accept) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fire) begin
            pc    <= target;
            // A response arriving alongside the redirect is simply dropped.
            state <= imem_rvalid ? S_REQ : S_DISCARD;
          end else if (imem_rvalid) begin
            if_instruction <= imem_rdata;
            if_pc_4        <= pc_plus4;
            pc             <= pc_plus4;
            if_valid       <= 1'b1;
            state          <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (fire) begin
            pc             <= target;
            if_valid       <= 1'b0;
            if_instruction <= BUBBLE_INSTR;
            if_pc_4        <= '0;
            state          <= S_REQ;
          end else if (consume) begin
            if_valid       <= 1'b0;
            if_instruction <= BUBBLE_INSTR;
            if_pc_4        <= '0;
            state          <= accept ? S_WAIT : S_REQ;
          end
        end
        S_DISCARD: begin
          if (fire) begin
            pc <= target;
          end
          // The stale response retires the outstanding request; nothing is left to wait for.
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
